// File: rtl/writeback_regfile_if.sv
// Bundle between the MEM/WB pipeline register, the decode stage and the
// write-back / register-file block.
//
// There is no valid/ready handshake on this bundle: every cycle the MEM/WB
// register presents exactly one instruction (bubbles arrive as NOPs). The
// register file consumes it unconditionally on the next rising edge. Read
// ports are purely combinational: data follows the address in the same cycle.
interface writeback_regfile_if #(
  parameter int WIDTH = 20
);
  // MEM/WB side
  logic [WIDTH-1:0] instruction;
  logic [WIDTH-1:0] aluRESULT;
  logic [WIDTH-1:0] memory_read_data;
  // decode-stage read ports
  logic [3:0]       read_addr_a;
  logic [3:0]       read_addr_b;
  logic [WIDTH-1:0] read_data_a;
  logic [WIDTH-1:0] read_data_b;
  // forwarding-unit view of the current write
  logic             wb_we;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  // committed register writes
  logic [15:0]      retired;

  // pipeline / decode side
  modport master (
    output instruction, aluRESULT, memory_read_data, read_addr_a, read_addr_b,
    input  read_data_a, read_data_b, wb_we, wb_addr, wb_data, retired
  );

  // write-back / register-file side
  modport slave (
    input  instruction, aluRESULT, memory_read_data, read_addr_a, read_addr_b,
    output read_data_a, read_data_b, wb_we, wb_addr, wb_data, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back stage and 16 x 20-bit architectural register file.
// Decodes the MEM/WB instruction, picks ALU result or load data, commits it
// on the rising edge, and serves two write-first bypassed read ports.
// Register 0 reads as zero and is never written. A saturating counter
// tracks committed register writes.
module writeback_regfile #(
  parameter int NREGS = 16,
  parameter int WIDTH = 20
) (
  input logic                clock,
  input logic                reset,
  writeback_regfile_if.slave bus
);

  localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

  logic [3:0]       opcode;
  logic [3:0]       rd;
  logic             instr_known;
  logic             writes_alu;
  logic             writes_mem;
  logic             wb_we;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] read_a;
  logic [WIDTH-1:0] read_b;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [15:0]      retired_q;
  logic [15:0]      retired_d;

  // Only opcode and rd matter here; the low instruction bits are ignored.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction[WIDTH-9:0];

  // Decode: opcode/rd fields, result select and write strobe. An unknown
  // opcode/rd (MEM/WB is not reset) behaves as a NOP.
  always_comb begin
    opcode      = bus.instruction[WIDTH-1 -: 4];
    rd          = bus.instruction[WIDTH-5 -: 4];
    instr_known = !$isunknown(bus.instruction[WIDTH-1 -: 8]);
    writes_alu  = 1'b0;
    writes_mem  = 1'b0;
    if (instr_known) begin
      case (opcode)
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: writes_alu = 1'b1;
        4'h7:                               writes_mem = 1'b1;
        default:                            ;
      endcase
    end
    wb_we   = (writes_alu || writes_mem) && (rd != 4'd0);
    wb_addr = rd;
    wb_data = writes_mem ? bus.memory_read_data : bus.aluRESULT;
  end

  // Read ports: r0 is zero, then write-first bypass, then the stored value.
  always_comb begin
    read_a = '0;
    read_b = '0;
    if (bus.read_addr_a != 4'd0) begin
      if (wb_we && (bus.read_addr_a == wb_addr)) read_a = wb_data;
      else                                       read_a = regs_q[bus.read_addr_a];
    end
    if (bus.read_addr_b != 4'd0) begin
      if (wb_we && (bus.read_addr_b == wb_addr)) read_b = wb_data;
      else                                       read_b = regs_q[bus.read_addr_b];
    end
  end

  // Next state: one register updated on a write, retire count saturates.
  always_comb begin
    regs_d    = regs_q;
    retired_d = retired_q;
    if (wb_we) begin
      regs_d[wb_addr] = wb_data;
      if (retired_q != RETIRED_MAX) retired_d = retired_q + 16'd1;
    end
  end

  // State registers; reset clears the file and counter immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      retired_q <= '0;
    end else begin
      regs_q    <= regs_d;
      retired_q <= retired_d;
    end
  end

  assign bus.read_data_a = read_a;
  assign bus.read_data_b = read_b;
  assign bus.wb_we       = wb_we;
  assign bus.wb_addr     = wb_addr;
  assign bus.wb_data     = wb_data;
  assign bus.retired     = retired_q;

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and architectural register file of the 20-bit pipelined processor. It sits directly downstream of the MEM/WB pipeline register. It decodes the propagated instruction, selects the ALU result or the memory read data, and commits the value to a 16 x 20-bit register file. The decode stage reads the file through two read ports with same-cycle write-through bypass; a retire counter tracks committed register writes.

## Interface
- `NREGS`, 16: number of architectural registers; fixed at 16 because of the 4-bit register fields.
- `WIDTH`, 20: datapath width.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Clears the register file and the retire counter immediately.
- `instruction` in 20: instruction from MEM/WB (`instructionPropagation`). Encoding:
  - opcode [19:16]
  - rd [15:12]
- `aluRESULT` in 20: ALU result from MEM/WB (`aluRESULTout`).
- `memory_read_data` in 20: load data from MEM/WB (`memory_read_data_out`).
- `read_addr_a` in 4: read port A address, from decode.
- `read_addr_b` in 4: read port B address, from decode.
- `read_data_a` out 20: port A data, combinational, bypassed.
- `read_data_b` out 20: port B data, combinational, bypassed.
- `wb_we` out 1: combinational write strobe of the current instruction, for the forwarding unit.
- `wb_addr` out 4: destination register (rd) of the current write.
- `wb_data` out 20: value being written this cycle.
- `retired` out 16: count of committed register writes, saturating.

## Operation
- Opcode decode:
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 SLT, 0x6 LI: write `aluRESULT`.
  - 0x7 LW: write `memory_read_data`.
  - 0x0 NOP, 0x8 SW, 0x9 BEQ, 0xA J, 0xB–0xF: no write.
- Write-enable rules:
  - `wb_we` = writing opcode AND rd != 0.
  - Register 0 is hardwired zero. Writes to rd = 0 are dropped and do not count as retired.
  - If any bit of `instruction[19:12]` is X/Z, the instruction is treated as a NOP. The MEM/WB instruction field is not cleared by reset, so this case occurs in the first cycle after reset.
- Register file update: on the rising edge with `wb_we`=1, regs[rd] <= `wb_data`. All other registers hold.
- Read ports:
  - `read_data_x` = 0 if addr = 0.
  - Otherwise `wb_data` if `wb_we` and addr == `wb_addr` (write-first bypass).
  - Otherwise regs[addr].
  - Both ports bypass independently; both may hit the same register.
- Retire counter:
  - Increments by 1 on each edge where `wb_we`=1.
  - Saturates at 0xFFFF and holds.
- Reset:
  - While `reset`=0: all registers and `retired` read 0. The read ports therefore return 0, except on a bypass hit, which returns `wb_data`.
  - A write edge coinciding with asserted reset is lost.
  - Deassertion is synchronized by the surrounding design; this block requires no extra handling.
- Arithmetic: no arithmetic on the data path. Values are stored unmodified at 20 bits.

## Timing
- Write latency: value visible in regs one edge after presentation; visible on the read ports in the same cycle via bypass.
- Read latency: 0 cycles, combinational from address.
- `wb_we`, `wb_addr`, `wb_data`: combinational from the inputs, same cycle.
- `retired`: updates on the same edge as the register write.
- Reset values:
  - All registers = 0.
  - `retired` = 0.
  - `read_data_a` and `read_data_b` = 0 when not bypassing.
  - `wb_*` follow their inputs (combinational).

## Test plan
- Reset, then an X instruction on the first cycle → `wb_we`=0, no register changes, `retired`=0; all read ports return 0.
- ADD with rd=3 and `aluRESULT`=0x12345, `read_addr_a`=3 in the same cycle → `read_data_a`=0x12345 (bypass). After the edge, regs[3]=0x12345 and `retired`=1.
- LW with rd=5, `memory_read_data`=0xABCDE, `aluRESULT`=0x00011 → regs[5]=0xABCDE, not 0x00011.
- SW, BEQ, and LI with rd=0 (`aluRESULT`=0xFFFFF) → no writes, `retired` unchanged, reads of r0 return 0.
- Write r7=0x00001, then assert `reset` low mid-cycle with no clock edge → regs[7] reads 0 immediately and `retired`=0.
- Preload `retired` to 0xFFFE by issuing 65534 writes, then issue 3 more → `retired` goes 0xFFFF and holds; port A and port B both reading the written register return the same bypassed value.
